// File: rtl/branch_predictor_pkg.sv
// Shared fetch-side definitions: instruction/PC widths, reset PC, 2-bit counter encodings.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package branch_predictor_pkg;

    // Instruction-type widths used across the fetch path.
    localparam int INST_W = 32;
    localparam int PC_W   = 32;

    // Default fetch address after reset.
    localparam logic [PC_W-1:0] RESET_PC_DEF = 32'h1c00_0000;

    // 2-bit saturating direction counter.
    localparam int CNT_W = 2;

    typedef enum logic [CNT_W-1:0] {
        CNT_SNT = 2'd0,   // strong not-taken
        CNT_WNT = 2'd1,   // weak not-taken
        CNT_WT  = 2'd2,   // weak taken
        CNT_ST  = 2'd3    // strong taken
    } cnt_e;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// 2-bit saturating counter next-state: +1 on taken (sat at 3), -1 on not-taken (sat at 0).
// Latency: combinational.
// Backpressure: none.
// Ports: i_count - current counter, i_taken - resolved direction, o_count - next counter.
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  logic [CNT_W-1:0] i_count,
    input  logic             i_taken,
    output logic [CNT_W-1:0] o_count
);

    always_comb begin
        o_count = i_count;
        if (i_taken) begin
            if (i_count != CNT_ST) o_count = i_count + 2'd1;
        end else begin
            if (i_count != CNT_SNT) o_count = i_count - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Fetch PC generator with a direct-mapped flop BTB and 2-bit direction counters.
// Latency: pred_PC combinational from fetch_PC; redirects and table updates take effect next cycle.
// Backpressure: stall holds fetch_PC only; redirects and table updates are never blocked.
// Ports: clk/reset (sync, active-high); stall; br_* resolved-branch feedback;
//        fetch_PC current fetch address; pred_PC predicted successor of fetch_PC.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int               BTB_ENTRIES = 16,
    parameter logic [PC_W-1:0]  RESET_PC    = RESET_PC_DEF
)(
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            br_valid,
    input  logic [31:0]     br_inst_PC,
    input  logic            br_is_branch,
    input  logic [31:0]     br_next_PC,
    input  logic            br_cancel,
    output logic [31:0]     fetch_PC,
    output logic [31:0]     pred_PC
);

    localparam int IDX   = $clog2(BTB_ENTRIES);
    localparam int TAG_W = 32 - IDX - 2;

    // Table storage; valid and counter are reset, tag and target are not.
    logic             r_valid  [BTB_ENTRIES];
    logic [TAG_W-1:0] r_tag    [BTB_ENTRIES];
    logic [31:0]      r_target [BTB_ENTRIES];
    logic [CNT_W-1:0] r_cnt    [BTB_ENTRIES];

    logic [31:0]      r_fetch_pc;

    // Lookup side
    logic [IDX-1:0]   w_lk_idx;
    logic [TAG_W-1:0] w_lk_tag;
    logic             w_lk_hit;
    logic [31:0]      w_seq_pc;

    // Update side
    logic [IDX-1:0]   w_up_idx;
    logic [TAG_W-1:0] w_up_tag;
    logic             w_up_hit;
    logic             w_up_en;
    logic             w_actual_taken;
    logic [CNT_W-1:0] w_cnt_next;
    logic [31:0]      w_fetch_next;

    assign fetch_PC = r_fetch_pc;

    assign w_lk_idx = r_fetch_pc[IDX+1:2];
    assign w_lk_tag = r_fetch_pc[31:IDX+2];
    assign w_lk_hit = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    assign w_seq_pc = r_fetch_pc + 32'd4;

    // Reads the registered table, so a same-cycle update to this index is not seen yet.
    assign pred_PC = (w_lk_hit && r_cnt[w_lk_idx][1]) ? r_target[w_lk_idx] : w_seq_pc;

    assign w_up_idx       = br_inst_PC[IDX+1:2];
    assign w_up_tag       = br_inst_PC[31:IDX+2];
    assign w_up_hit       = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
    assign w_up_en        = br_valid && br_is_branch;
    // Any successor other than the fall-through counts as taken (covers jumps too).
    assign w_actual_taken = (br_next_PC != (br_inst_PC + 32'd4));

    sat_counter2 u_sat_counter2 (
        .i_count (r_cnt[w_up_idx]),
        .i_taken (w_actual_taken),
        .o_count (w_cnt_next)
    );

    // Redirect wins over stall; cancel is honoured for non-branch instructions too.
    always_comb begin
        w_fetch_next = pred_PC;
        if (br_valid && br_cancel) begin
            w_fetch_next = br_next_PC;
        end else if (stall) begin
            w_fetch_next = r_fetch_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
                r_cnt[i]   <= CNT_SNT;
            end
        end else begin
            r_fetch_pc <= w_fetch_next;
            if (w_up_en) begin
                if (w_up_hit) begin
                    r_cnt[w_up_idx] <= w_cnt_next;
                    if (w_actual_taken) r_target[w_up_idx] <= br_next_PC;
                end else if (w_actual_taken) begin
                    // Allocation on a taken miss evicts whatever aliased here.
                    r_valid[w_up_idx]  <= 1'b1;
                    r_tag[w_up_idx]    <= w_up_tag;
                    r_target[w_up_idx] <= br_next_PC;
                    r_cnt[w_up_idx]    <= CNT_WT;
                end
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: reference model feeds a scoreboard of expected fetch_PC/pred_PC.
// Latency: one expected entry per clock, compared 1ns after the edge.
// Backpressure: n/a.
module tb_branch_predictor;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        br_valid;
    logic [31:0] br_inst_PC;
    logic        br_is_branch;
    logic [31:0] br_next_PC;
    logic        br_cancel;
    logic [31:0] fetch_PC;
    logic [31:0] pred_PC;

    branch_predictor dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .br_valid     (br_valid),
        .br_inst_PC   (br_inst_PC),
        .br_is_branch (br_is_branch),
        .br_next_PC   (br_next_PC),
        .br_cancel    (br_cancel),
        .fetch_PC     (fetch_PC),
        .pred_PC      (pred_PC)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Reference model: each entry remembers the owning word address (PC[31:2]).
    logic        m_valid [16];
    logic [29:0] m_owner [16];
    logic [31:0] m_tgt   [16];
    int          m_cnt   [16];
    logic [31:0] m_fetch;
    bit          m_init = 0;

    typedef struct packed {
        logic [31:0] f;
        logic [31:0] p;
    } exp_t;
    exp_t sb_q[$];

    function automatic logic [31:0] m_pred(input logic [31:0] pc);
        int i;
        i = int'(pc[5:2]);
        if (m_valid[i] && m_owner[i] == pc[31:2] && m_cnt[i] >= 2) return m_tgt[i];
        return pc + 32'd4;
    endfunction

    task automatic cyc(input bit rst, input bit stl, input bit bv, input logic [31:0] bpc,
                       input bit bbr, input logic [31:0] bnext, input bit bcan);
        logic [31:0] pnow;
        logic [31:0] nf;
        bit          tkn;
        int          i;
        exp_t        e;
        reset        = rst;
        stall        = stl;
        br_valid     = bv;
        br_inst_PC   = bpc;
        br_is_branch = bbr;
        br_next_PC   = bnext;
        br_cancel    = bcan;
        #1;
        pnow = m_pred(m_fetch);
        // Lookup must reflect the table before this cycle's update.
        if (m_init) chk("pred_pre_edge", pred_PC, pnow);
        if (rst) begin
            m_fetch = 32'h1c00_0000;
            for (int k = 0; k < 16; k++) begin
                m_valid[k] = 1'b0;
                m_cnt[k]   = 0;
            end
            m_init = 1;
        end else begin
            if (bv && bcan)  nf = bnext;
            else if (stl)    nf = m_fetch;
            else             nf = pnow;
            if (bv && bbr) begin
                tkn = (bnext != bpc + 32'd4);
                i   = int'(bpc[5:2]);
                if (m_valid[i] && m_owner[i] == bpc[31:2]) begin
                    if (tkn) begin
                        m_cnt[i] = (m_cnt[i] == 3) ? 3 : m_cnt[i] + 1;
                        m_tgt[i] = bnext;
                    end else begin
                        m_cnt[i] = (m_cnt[i] == 0) ? 0 : m_cnt[i] - 1;
                    end
                end else if (tkn) begin
                    m_valid[i] = 1'b1;
                    m_owner[i] = bpc[31:2];
                    m_tgt[i]   = bnext;
                    m_cnt[i]   = 2;
                end
            end
            m_fetch = nf;
        end
        e.f = m_fetch;
        e.p = m_pred(m_fetch);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk("sb_fetch", fetch_PC, e.f);
        chk("sb_pred",  pred_PC,  e.p);
    endtask

    task automatic idle();
        cyc(0, 0, 0, 32'h0, 0, 32'h0, 0);
    endtask

    // Non-branch cancel: moves fetch without touching the table.
    task automatic redirect(input logic [31:0] pc, input bit stl);
        cyc(0, stl, 1, 32'h1c00_0000, 0, pc, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc(1, 0, 0, 32'h0, 0, 32'h0, 0);
        cyc(1, 1, 1, 32'h1c00_0010, 1, 32'h1c00_0100, 1);
        chk("rst_fetch", fetch_PC, 32'h1c00_0000);
        chk("rst_pred",  pred_PC,  32'h1c00_0004);

        // Sequential fetch
        idle();
        chk("seq_1", fetch_PC, 32'h1c00_0004);
        idle();
        chk("seq_2", fetch_PC, 32'h1c00_0008);

        // Taken branch with cancel: redirect and allocate
        cyc(0, 0, 1, 32'h1c00_0010, 1, 32'h1c00_0100, 1);
        chk("redir_taken", fetch_PC, 32'h1c00_0100);
        redirect(32'h1c00_0010, 0);
        chk("alloc_pred", pred_PC, 32'h1c00_0100);
        idle();
        chk("follow_pred", fetch_PC, 32'h1c00_0100);

        // Not-taken training while fetch is held at the branch
        redirect(32'h1c00_0010, 0);
        cyc(0, 1, 1, 32'h1c00_0010, 1, 32'h1c00_0014, 0);
        chk("nt1_pred", pred_PC, 32'h1c00_0014);
        chk("stall_hold", fetch_PC, 32'h1c00_0010);
        cyc(0, 1, 1, 32'h1c00_0010, 1, 32'h1c00_0014, 0);
        chk("nt2_pred", pred_PC, 32'h1c00_0014);
        cyc(0, 1, 1, 32'h1c00_0010, 1, 32'h1c00_0014, 0);
        chk("nt3_pred", pred_PC, 32'h1c00_0014);
        // Counter must be exactly 0: one taken -> 1 (still NT), second -> 2 (T)
        cyc(0, 1, 1, 32'h1c00_0010, 1, 32'h1c00_0100, 0);
        chk("sat0_t1", pred_PC, 32'h1c00_0014);
        cyc(0, 1, 1, 32'h1c00_0010, 1, 32'h1c00_0100, 0);
        chk("sat0_t2", pred_PC, 32'h1c00_0100);

        // Cancel beats stall
        redirect(32'h1c00_0200, 1);
        chk("cancel_over_stall", fetch_PC, 32'h1c00_0200);

        // Cancel without br_valid is ignored
        cyc(0, 1, 0, 32'h1c00_0000, 1, 32'h1c00_0300, 1);
        chk("cancel_no_valid", fetch_PC, 32'h1c00_0200);

        // Aliasing replacement at index 4
        cyc(0, 1, 1, 32'h1c00_0050, 1, 32'h1c00_0300, 0);
        redirect(32'h1c00_0010, 0);
        chk("alias_old_miss", pred_PC, 32'h1c00_0014);
        redirect(32'h1c00_0050, 0);
        chk("alias_new_hit", pred_PC, 32'h1c00_0300);

        // Reset beats redirect and update
        cyc(1, 0, 1, 32'h1c00_0020, 1, 32'h1c00_0400, 1);
        chk("rst_over_cancel", fetch_PC, 32'h1c00_0000);
        redirect(32'h1c00_0050, 0);
        chk("rst_clear_50", pred_PC, 32'h1c00_0054);
        redirect(32'h1c00_0020, 0);
        chk("rst_drop_upd", pred_PC, 32'h1c00_0024);

        // Random traffic over a small PC window to force hits and aliasing
        for (int n = 0; n < 400; n++) begin
            logic [31:0] bpc;
            logic [31:0] bnx;
            bpc = 32'h1c00_0000 + (32'($urandom_range(0, 63)) << 2);
            if ($urandom_range(0, 1) == 0) bnx = bpc + 32'd4;
            else                            bnx = 32'h1c00_0000 + (32'($urandom_range(0, 63)) << 2);
            cyc(($urandom_range(0, 99) < 2), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 1) == 1), bpc, ($urandom_range(0, 3) != 0),
                bnx, ($urandom_range(0, 2) == 0));
        end

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 The block SHALL have one clock, clk; reset is synchronous and active-high, named reset.
REQ-002 Port list, one per line (name, direction, width, meaning), clock and reset first:
- clk  in  1  core clock
- reset  in  1  synchronous active-high reset
- stall  in  1  fetch stage held; PC does not advance
- br_valid  in  1  resolved branch present this cycle (from the branch resolution stage)
- br_inst_PC  in  32  PC of the resolved instruction
- br_is_branch  in  1  resolved instruction is a control-transfer instruction
- br_next_PC  in  32  architecturally correct successor PC
- br_cancel  in  1  misprediction flag from the branch resolution stage
- fetch_PC  out  32  PC presented to instruction fetch this cycle
- pred_PC  out  32  predicted successor of fetch_PC; travels down the pipe with the instruction
REQ-003 Parameters, one per line (name, default, meaning):
- BTB_ENTRIES, 16, direct-mapped BTB depth; power of two
- RESET_PC, 32'h1c00_0000, fetch_PC after reset

Function
REQ-004 Index SHALL be fetch_PC[IDX+1:2] and tag SHALL be fetch_PC[31:IDX+2], where IDX = log2(BTB_ENTRIES).
REQ-005 Each entry SHALL hold a valid bit, a tag, a 32-bit target, and a 2-bit saturating counter (0 = strong-NT, 1 = weak-NT, 2 = weak-T, 3 = strong-T).
REQ-006 pred_PC SHALL be combinational from the current table state: it equals the entry target when the entry is valid, the tag matches, and counter[1] = 1; otherwise it equals fetch_PC + 4 (mod 2^32).
REQ-007 fetch_PC register next-state, in priority order:
- br_valid & br_cancel: br_next_PC
- stall: hold
- otherwise: pred_PC
REQ-008 actual_taken SHALL equal (br_next_PC != br_inst_PC + 4).
REQ-009 Table update occurs only when br_valid & br_is_branch. The update is written at the clock edge and is visible to lookups from the next cycle.
REQ-010 Update on a hit (valid and tag match at the br_inst_PC index): the counter increments, saturating at 3, if actual_taken; otherwise it decrements, saturating at 0. The target is overwritten with br_next_PC only when actual_taken.
REQ-011 Update on a miss with actual_taken: the entry is allocated (replacing any existing contents) with valid = 1, tag, target = br_next_PC, and counter = 2.
REQ-012 Update on a miss with !actual_taken: the table is not changed.
REQ-013 When a lookup and an update hit the same index in one cycle, the lookup SHALL return the pre-update contents.
REQ-014 br_cancel with br_valid = 0 SHALL be ignored. br_cancel SHALL redirect fetch_PC even when br_is_branch = 0.
REQ-015 stall SHALL NOT block table updates.
REQ-016 Latency: a redirect appears on fetch_PC one cycle after br_cancel is sampled; an allocated entry is usable for prediction one cycle after the update.

Reset
REQ-017 While reset is high, fetch_PC SHALL load RESET_PC and all valid bits and counters SHALL clear to 0. Targets and tags are don't-care.
REQ-018 Reset SHALL override redirect, stall, and update in the same cycle.
REQ-019 pred_PC SHALL be RESET_PC + 4 in the first cycle after reset.
REQ-020 Reset asserted mid-operation SHALL discard any in-flight update.

Structure
REQ-021 RESET_PC default, the counter encodings, and the 2-bit counter width SHALL live in the shared include header alongside the existing instruction-type width defines.
REQ-022 The 2-bit saturating counter update SHALL be a sub-module, sat_counter2 (input count, input taken, output next count).
REQ-023 The table SHALL be flop-based, giving single-cycle combinational read and no SRAM.

Verification
REQ-024 Reset, then run 3 cycles with no stall -> fetch_PC sequence is 1c000000, 1c000004, 1c000008.
REQ-025 Taken branch br_inst_PC = 1c000010, br_next_PC = 1c000100, with br_cancel -> the next cycle fetch_PC = 1c000100. When fetch later reaches 1c000010 -> pred_PC = 1c000100 (counter 2).
REQ-026 Same PC resolved not-taken twice (br_next_PC = 1c000014) -> the counter goes 2 -> 1 -> 0 and pred_PC at 1c000010 = 1c000014. A third not-taken leaves the counter at 0.
REQ-027 stall and br_cancel asserted together with br_next_PC = 1c000200 -> fetch_PC = 1c000200 next cycle.
REQ-028 Aliasing: entry allocated for 1c000010, then a taken branch at 1c000050 (same index for 16 entries) -> the entry is replaced; lookup at 1c000010 misses and predicts 1c000014.
REQ-029 Reset asserted in the same cycle as br_valid & br_cancel -> fetch_PC = 1c000000 and the table is empty afterwards.
